// File: rtl/fc_pkg.sv
// Shared types and default timing constants for the ESC pulse path.
package fc_pkg;

  localparam int CMD_W        = 8;
  localparam int DEF_MIN_US   = 1000;
  localparam int DEF_MAX_US   = 2000;
  localparam int DEF_FRAME_US = 2500;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAILSAFE = 2'd3
  } state_t;

  // Throttle-to-extra-microseconds: (cmd * span) >> 8 in a 19-bit product.
  function automatic logic [18:0] scale_cmd(input logic [CMD_W-1:0] c, input int span);
    logic [18:0] prod;
    prod = 19'(c) * 19'(span);
    return prod >> 8;
  endfunction

endpackage

// File: rtl/pulse_timebase.sv
// Prescaler plus microsecond-in-frame counter; frame_tick marks the first clk of a frame.
module pulse_timebase #(
  parameter int TICKS_PER_US = 12,
  parameter int FRAME_US     = 2500,
  parameter int UW           = (FRAME_US > 1) ? $clog2(FRAME_US) : 1
)(
  input  logic          i_clk,
  input  logic          i_rst,
  output logic          o_us_tick,
  output logic          o_frame_tick,
  output logic [UW-1:0] o_us_cnt
);
  localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  logic [PW-1:0] r_pre;
  logic [UW-1:0] r_us;

  assign o_us_tick    = (r_pre == PW'(TICKS_PER_US - 1));
  assign o_frame_tick = (r_pre == '0) && (r_us == '0);
  assign o_us_cnt     = r_us;

  // Prescaler wraps every TICKS_PER_US clks and advances the frame position.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre <= '0;
      r_us  <= '0;
    end else if (o_us_tick) begin
      r_pre <= '0;
      r_us  <= (r_us == UW'(FRAME_US - 1)) ? '0 : r_us + UW'(1);
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

endmodule

// File: rtl/esc_pulse_transmitter.sv
// RC/ESC servo pulse transmitter: frame-aligned command latch, arming FSM, timeout failsafe.
module esc_pulse_transmitter
  import fc_pkg::*;
#(
  parameter int TICKS_PER_US   = 12,
  parameter int FRAME_US       = DEF_FRAME_US,
  parameter int MIN_US         = DEF_MIN_US,
  parameter int MAX_US         = DEF_MAX_US,
  parameter int ARM_FRAMES     = 10,
  parameter int TIMEOUT_FRAMES = 20
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd,
  input  logic             arm_req,
  output logic             pulse_out,
  output logic             frame_start,
  output logic             armed,
  output logic             failsafe
);
  localparam int UW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam int AW = $clog2(ARM_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);

  logic             w_us_tick, w_frame_tick;
  logic [UW-1:0]    w_us_cnt;
  logic             w_accept, w_acc_frame;
  logic [CMD_W-1:0] w_next_cmd;
  logic [UW-1:0]    w_width;
  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_arm_cnt, w_arm_cnt_nxt;
  logic [TW-1:0]    r_to_cnt, w_to_cnt_nxt;
  logic [CMD_W-1:0] r_pend, r_active;
  logic             r_pend_full, r_acc_seen;
  logic [UW-1:0]    r_width;
  logic             r_pulse, r_at_end, r_frame_start, r_armed, r_failsafe;

  pulse_timebase #(.TICKS_PER_US(TICKS_PER_US), .FRAME_US(FRAME_US), .UW(UW)) u_tb (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_us_tick    (w_us_tick),
    .o_frame_tick (w_frame_tick),
    .o_us_cnt     (w_us_cnt)
  );

  // One pending slot; the frame boundary always drains it, so a stalled sender lands there.
  assign cmd_ready   = ~rst & (~r_pend_full | w_frame_tick);
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_next_cmd  = w_accept ? cmd : (r_pend_full ? r_pend : r_active);
  assign w_acc_frame = r_acc_seen | w_accept;

  // Pending register and active command; active only changes on the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_active    <= '0;
      r_acc_seen  <= 1'b0;
    end else if (w_frame_tick) begin
      r_active    <= w_next_cmd;
      r_pend_full <= 1'b0;
      r_acc_seen  <= 1'b0;
    end else if (w_accept) begin
      r_pend      <= cmd;
      r_pend_full <= 1'b1;
      r_acc_seen  <= 1'b1;
    end
  end

  // Next state and frame counters, evaluated only at the frame boundary.
  always_comb begin
    w_state_nxt   = r_state;
    w_arm_cnt_nxt = r_arm_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    if (w_frame_tick) begin
      unique case (r_state)
        ST_DISARMED: begin
          if (arm_req && (w_next_cmd == '0)) begin
            w_to_cnt_nxt = '0;
            if (ARM_FRAMES <= 1) begin
              w_state_nxt = ST_ARMED;
            end else begin
              w_state_nxt   = ST_ARMING;
              w_arm_cnt_nxt = AW'(1);
            end
          end
        end
        ST_ARMING: begin
          if (arm_req && (w_next_cmd == '0)) begin
            w_arm_cnt_nxt = r_arm_cnt + AW'(1);
            if (w_arm_cnt_nxt == AW'(ARM_FRAMES)) begin
              w_state_nxt   = ST_ARMED;
              w_arm_cnt_nxt = '0;
              w_to_cnt_nxt  = '0;
            end
          end else begin
            w_state_nxt   = ST_DISARMED;
            w_arm_cnt_nxt = '0;
          end
        end
        ST_ARMED: begin
          if (!arm_req) begin
            w_state_nxt  = ST_DISARMED;
            w_to_cnt_nxt = '0;
          end else if (w_acc_frame) begin
            w_to_cnt_nxt = '0;
          end else begin
            w_to_cnt_nxt = r_to_cnt + TW'(1);
            if (w_to_cnt_nxt == TW'(TIMEOUT_FRAMES)) begin
              w_state_nxt  = ST_FAILSAFE;
              w_to_cnt_nxt = '0;
            end
          end
        end
        ST_FAILSAFE: begin
          if (!arm_req) w_state_nxt = ST_DISARMED;
        end
        default: w_state_nxt = ST_DISARMED;
      endcase
    end
  end

  // Width for the frame about to start, from post-update state and command.
  always_comb begin
    w_width = UW'(MIN_US);
    if (w_state_nxt == ST_ARMED)
      w_width = UW'(MIN_US + int'(scale_cmd(w_next_cmd, MAX_US - MIN_US)));
  end

  // State register and registered flags; flags move together with frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_DISARMED;
      r_arm_cnt  <= '0;
      r_to_cnt   <= '0;
      r_armed    <= 1'b0;
      r_failsafe <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_arm_cnt  <= w_arm_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_armed    <= (w_state_nxt == ST_ARMED);
      r_failsafe <= (w_state_nxt == ST_FAILSAFE);
    end
  end

  // Pulse rises with frame_start; r_at_end flags the clk just past width_us microseconds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_width       <= UW'(MIN_US);
      r_pulse       <= 1'b0;
      r_at_end      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_tick;
      r_at_end      <= w_us_tick && (w_us_cnt == r_width - UW'(1));
      if (w_frame_tick) begin
        r_width <= w_width;
        r_pulse <= 1'b1;
      end else if (r_at_end) begin
        r_pulse <= 1'b0;
      end
    end
  end

  assign pulse_out   = r_pulse;
  assign frame_start = r_frame_start;
  assign armed       = r_armed;
  assign failsafe    = r_failsafe;

endmodule

// File: tb/tb_esc_pulse_transmitter.sv
// Directed bench for esc_pulse_transmitter. Time constants are scaled down
// (1 clk/us, 250 us frame, 100..200 us pulse) to keep runs short.
module tb_esc_pulse_transmitter;
  localparam int FRAME = 250;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd;
  logic       arm_req;
  logic       pulse_out, frame_start, armed, failsafe;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic la, lf;

  esc_pulse_transmitter #(
    .TICKS_PER_US(1), .FRAME_US(FRAME), .MIN_US(100), .MAX_US(200),
    .ARM_FRAMES(10), .TIMEOUT_FRAMES(20)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .arm_req(arm_req), .pulse_out(pulse_out),
    .frame_start(frame_start), .armed(armed), .failsafe(failsafe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Count negedges until frame_start is seen (bounded).
  task automatic wait_fs(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 400);
  endtask

  // Entered on the frame_start negedge; measures one frame up to the next frame_start.
  task automatic frm(input string tag, input int exp_hi);
    int hi, len;
    hi = 0; len = 0; la = armed; lf = failsafe;
    do begin
      hi += int'(pulse_out); len++;
      @(negedge clk);
    end while (!frame_start && len < 400);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_len"}, len, FRAME);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, hi5;
    rst = 1'b1; cmd_valid = 1'b1; cmd = 8'd200; arm_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pulse", int'(pulse_out), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_failsafe", int'(failsafe), 0);
    chk("rst_ready", int'(cmd_ready), 0);

    // 1: disarmed streaming, MIN width every frame
    rst = 1'b0;
    wait_fs(n);
    chk("t1_first_fs", n, 1);
    frm("t1a", 100);
    chk("t1_armed", int'(la), 0);
    frm("t1b", 100);

    // 2: arm with zero throttle, then scaled widths
    arm_req = 1'b1; cmd = 8'd0;
    frm("t2_f0", 100);
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      frm("t2_arm", 100);
      if (i < 10) cnt += int'(la);
      else chk("t2_armed_at10", int'(la), 1);
    end
    chk("t2_not_early", cnt, 0);
    cmd = 8'd128;
    frm("t2_c0", 100);
    frm("t2_c128", 150);
    cmd = 8'd255;
    frm("t2_hold128", 150);
    frm("t2_c255", 199);
    cmd = 8'd0;
    frm("t2_hold255", 199);
    frm("t2_c0b", 100);

    // 3: nonzero command while arming restarts the count
    arm_req = 1'b0;
    frm("t3_drop", 100);
    arm_req = 1'b1;
    frm("t3_f0", 100);
    chk("t3_disarmed", int'(la), 0);
    cnt = 0;
    for (int j = 1; j <= 16; j++) begin
      if (j == 5) cmd = 8'd1;
      if (j == 6) cmd = 8'd0;
      frm("t3_arm", 100);
      if (j < 16) cnt += int'(la);
      else chk("t3_armed_at16", int'(la), 1);
    end
    chk("t3_not_early", cnt, 0);

    // 4: command timeout into failsafe
    cmd = 8'd128;
    frm("t4_pre", 100);
    cmd_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      frm("t4_to", 150);
      cnt += int'(lf);
    end
    chk("t4_no_fs_early", cnt, 0);
    cmd_valid = 1'b1; cmd = 8'd200;
    frm("t4_fs", 100);
    chk("t4_fs_flag", int'(lf), 1);
    frm("t4_fs_cmd", 100);
    chk("t4_fs_hold", int'(lf), 1);
    chk("t4_fs_armed", int'(la), 0);
    arm_req = 1'b0;
    frm("t4_fs_last", 100);
    frm("t4_dis", 100);
    chk("t4_dis_fs", int'(lf), 0);
    chk("t4_dis_armed", int'(la), 0);

    // 5: two mid-frame commands, the second stalls and wins at the boundary
    arm_req = 1'b1; cmd = 8'd0;
    frm("t5_f0", 100);
    for (int i = 0; i < 10; i++) frm("t5_arm", 100);
    chk("t5_armed", int'(la), 1);
    cmd_valid = 1'b0;
    hi5 = 0;
    for (int c = 0; c < FRAME; c++) begin
      hi5 += int'(pulse_out);
      if (c == 50) begin
        chk("t5_rdy_empty", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd = 8'd50;
      end
      if (c == 51) begin
        chk("t5_rdy_stall", int'(cmd_ready), 0);
        cmd = 8'd100;
      end
      if (c == FRAME - 1) chk("t5_rdy_tick", int'(cmd_ready), 1);
      @(negedge clk);
    end
    chk("t5_cur_hi", hi5, 100);
    chk("t5_fs", int'(frame_start), 1);
    frm("t5_new", 139);

    // 6: async reset during a high pulse
    repeat (20) @(negedge clk);
    chk("t6_pre_hi", int'(pulse_out), 1);
    chk("t6_pre_armed", int'(armed), 1);
    rst = 1'b1;
    #1;
    chk("t6_async_pulse", int'(pulse_out), 0);
    chk("t6_async_armed", int'(armed), 0);
    chk("t6_async_ready", int'(cmd_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_fs(n);
    chk("t6_first_fs", n, 1);
    frm("t6_after", 100);
    chk("t6_armed", int'(la), 0);
    frm("t6_after2", 100);
    chk("t6_still_dis", int'(la), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/esc_pulse_transmitter.md
Name: esc_pulse_transmitter

Overview:
Generates the standard RC/ESC servo pulse (1000–2000 us high time, fixed frame period) for one motor. It is the transmit end of the pulse protocol that the receiver readers decode. It takes 8-bit throttle commands over a valid/ready handshake and latches them only at frame boundaries, so no runt or stretched pulses are produced. It includes an arming state machine and a command-timeout failsafe, and sits between the mixer/summers and each motor pin.

Parameters:
TICKS_PER_US, 12, clk cycles per microsecond (prescaler terminal count + 1)
FRAME_US, 2500, frame period in us (400 Hz)
MIN_US, 1000, pulse width for cmd 0 / disarmed / failsafe
MAX_US, 2000, full-scale reference width
ARM_FRAMES, 10, consecutive zero-throttle frames with arm_req needed to arm
TIMEOUT_FRAMES, 20, frames without an accepted cmd before failsafe

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid & ready
cmd  in  8  throttle command, 0..255
arm_req  in  1  level request to arm
pulse_out  out  1  ESC pulse, registered
frame_start  out  1  one-cycle strobe on the first clk of each frame
armed  out  1  high in ARMED
failsafe  out  1  high in FAILSAFE

Behaviour:
- Reset: all counters 0; pend_full=0; active_cmd=0; state=DISARMED; pulse_out=0; frame_start=0; armed=0; failsafe=0; cmd_ready=0 while rst is high.
- After reset release, the first frame_start occurs on the first clk edge.
- Timebase: a prescaler counts 0..TICKS_PER_US-1 and emits us_tick; us_cnt counts 0..FRAME_US-1 and wraps to 0.
- frame_tick is asserted when prescaler==0 and us_cnt==0. frame_start is the registered frame_tick.
- Handshake: one-entry pending register. cmd_ready = ~pend_full | frame_tick.
  - An accept outside frame_tick sets pend_full.
  - At frame_tick: active_cmd <= accept ? cmd : (pend_full ? pend : active_cmd); pend_full <= 0. The newest command wins.
- Width latch at frame_tick uses the post-update state and active_cmd:
  - ARMED: width_us = MIN_US + ((active_cmd * (MAX_US-MIN_US)) >> 8), computed with a 19-bit unsigned intermediate.
  - Any other state: width_us = MIN_US.
- Pulse timing: pulse_out is high for exactly width_us*TICKS_PER_US clks, rising the clk after frame_tick. It is then low for the rest of the frame.
- Width constraint: width_us < FRAME_US is required. Parameters violating it are illegal.
- State machine, evaluated only at frame_tick (no mid-frame changes):
  - DISARMED -> ARMING if arm_req and the new active_cmd==0. arm_cnt=1.
  - ARMING: if arm_req and active_cmd==0, arm_cnt++. When arm_cnt reaches ARM_FRAMES -> ARMED. Otherwise (cmd≠0 or ~arm_req) -> DISARMED, arm_cnt=0.
  - ARMED: ~arm_req -> DISARMED. No accept during the frame just ended: to_cnt++; when to_cnt reaches TIMEOUT_FRAMES -> FAILSAFE. Any accept clears to_cnt.
  - FAILSAFE: width MIN_US; exits only when ~arm_req -> DISARMED. New commands are accepted but ignored until re-armed.
- Flag timing: armed and failsafe are registered decodes of state and update with frame_start.
- Reset mid-frame: pulse_out drops immediately (async). The frame restarts from us_cnt=0 after release.

Decomposition:
- Shared package fc_pkg:
  - state encoding (DISARMED, ARMING, ARMED, FAILSAFE)
  - default MIN_US / MAX_US / FRAME_US constants
  - CMD_W=8
- One sub-module, pulse_timebase: prescaler + us_cnt, outputs us_tick, frame_tick, us_cnt. It is reusable by pwm_generator variants.

Test Plan:
All tests use TICKS_PER_US=1, FRAME_US=2500, ARM_FRAMES=10, TIMEOUT_FRAMES=20 unless noted.
1. Release reset, arm_req=0, cmd=200 streaming -> every frame has pulse_out high exactly 1000 clks; armed=0; frame_start period 2500 clks.
2. arm_req=1, cmd=0 each frame -> armed rises with the 10th frame_start. Then cmd=128 -> next frame pulse 1500 clks; cmd=255 -> 1996 clks; cmd=0 -> 1000 clks.
3. While ARMING (frame 5), send cmd=1 -> return to DISARMED; armed stays 0; a full 10 further zero frames are required.
4. Armed at cmd=128, stop cmd_valid -> 20 frames at 1500 clks, then failsafe=1 and 1000-clk pulses. Resume cmds -> still 1000. Drop arm_req -> DISARMED, failsafe=0.
5. Mid-frame send cmd=50 then cmd=100 (second stalls: cmd_ready=0 until frame_tick, accepted on it) -> next frame width corresponds to 100 (1390 clks). The in-progress pulse is unchanged.
6. Assert rst during a high pulse -> pulse_out=0 asynchronously, state DISARMED, armed=0. After release, frame_start on the first clk and a 1000-clk pulse.
